// File: rtl/dpu_apb_pkg.sv
// Shared types and constants for the DPU CSR APB arbiter slice.
// FSM state encoding, CSR address map and known CSR values.
package dpu_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

  localparam logic [31:0] CSRA_VERSION = 32'h0000_0000;
  localparam logic [31:0] CSRA_CONFIG  = 32'h0000_0010;
  localparam logic [31:0] CSRA_STATUS  = 32'h0000_0020;

  localparam logic [31:0] CSR_VERSION_VAL = 32'h2021_0610;

  // CONFIG register layout: {address width, data width}, 16 bits each.
  function automatic logic [31:0] csr_config_val(input int ad,
                                                 input int da);
    return {16'(ad), 16'(da)};
  endfunction

endpackage

// File: rtl/dpu_rr_arbiter.sv
// Combinational round-robin pick: search from ptr+1 upward, wrapping.
// Ports: req (requests), ptr (last winner) -> gnt (one-hot), idx (binary).
module dpu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic found;

  always_comb begin : pick
    int j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dpu_apb_arbiter.sv
// Round-robin sharing of one APB master among NUM_REQ requesters.
// Ports: REQ/REQ_* in, ACK/ERR/RDATA out; P* APB master interface.
module dpu_apb_arbiter
  import dpu_apb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int APB_WIDTH_AD = 32,
  parameter int APB_WIDTH_DA = 32,
  parameter int TIMEOUT      = 16
) (
  input  logic                            PRESETn,
  input  logic                            PCLK,
  input  logic [NUM_REQ-1:0]              REQ,
  input  logic [NUM_REQ-1:0]              REQ_WRITE,
  input  logic [NUM_REQ*APB_WIDTH_AD-1:0] REQ_ADDR,
  input  logic [NUM_REQ*APB_WIDTH_DA-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]              ACK,
  output logic                            ERR,
  output logic [APB_WIDTH_DA-1:0]         RDATA,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic [APB_WIDTH_AD-1:0]         PADDR,
  output logic                            PWRITE,
  output logic [APB_WIDTH_DA-1:0]         PWDATA,
  input  logic                            PREADY,
  input  logic                            PSLVERR,
  input  logic [APB_WIDTH_DA-1:0]         PRDATA
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e state, state_nxt;

  logic [IW-1:0]           ptr, ptr_nxt;
  logic [IW-1:0]           win, win_nxt;
  logic [NUM_REQ-1:0]      win_oh, win_oh_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;

  logic                    psel_nxt;
  logic                    penable_nxt;
  logic [APB_WIDTH_AD-1:0] paddr_nxt;
  logic                    pwrite_nxt;
  logic [APB_WIDTH_DA-1:0] pwdata_nxt;
  logic [NUM_REQ-1:0]      ack_nxt;
  logic                    err_nxt;
  logic [APB_WIDTH_DA-1:0] rdata_nxt;

  logic [NUM_REQ-1:0]      gnt;
  logic [IW-1:0]           gnt_idx;

  dpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req (REQ),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      ptr     <= IW'(NUM_REQ - 1);
      win     <= '0;
      win_oh  <= '0;
      cnt     <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      ACK     <= '0;
      ERR     <= 1'b0;
      RDATA   <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win     <= win_nxt;
      win_oh  <= win_oh_nxt;
      cnt     <= cnt_nxt;
      PSEL    <= psel_nxt;
      PENABLE <= penable_nxt;
      PADDR   <= paddr_nxt;
      PWRITE  <= pwrite_nxt;
      PWDATA  <= pwdata_nxt;
      ACK     <= ack_nxt;
      ERR     <= err_nxt;
      RDATA   <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win;
    win_oh_nxt  = win_oh;
    cnt_nxt     = cnt;
    psel_nxt    = PSEL;
    penable_nxt = PENABLE;
    paddr_nxt   = PADDR;
    pwrite_nxt  = PWRITE;
    pwdata_nxt  = PWDATA;
    // Completion outputs are single-cycle; they default low.
    ack_nxt     = '0;
    err_nxt     = 1'b0;
    rdata_nxt   = '0;

    unique case (state)
      IDLE: begin
        if (|REQ) begin
          win_nxt     = gnt_idx;
          win_oh_nxt  = gnt;
          paddr_nxt   = REQ_ADDR[int'(gnt_idx)*APB_WIDTH_AD +: APB_WIDTH_AD];
          pwdata_nxt  = REQ_WDATA[int'(gnt_idx)*APB_WIDTH_DA +: APB_WIDTH_DA];
          pwrite_nxt  = REQ_WRITE[gnt_idx];
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          rdata_nxt   = PWRITE ? '0 : PRDATA;
          err_nxt     = PSLVERR;
          ack_nxt     = win_oh;
          ptr_nxt     = win;
          state_nxt   = DONE;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          // Abort still acks and rotates priority.
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          err_nxt     = 1'b1;
          ack_nxt     = win_oh;
          ptr_nxt     = win;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dpu_apb_arbiter.sv
// Directed scoreboard bench for dpu_apb_arbiter with a small CSR slave.
// Ports: none; drives PCLK/PRESETn and all requester/APB inputs.
module tb_dpu_apb_arbiter;
  import dpu_apb_pkg::*;

  localparam int N  = 2;
  localparam int AD = 32;
  localparam int DA = 32;

  logic            PRESETn;
  logic            PCLK;
  logic [N-1:0]    REQ;
  logic [N-1:0]    REQ_WRITE;
  logic [N*AD-1:0] REQ_ADDR;
  logic [N*DA-1:0] REQ_WDATA;
  logic [N-1:0]    ACK;
  logic            ERR;
  logic [DA-1:0]   RDATA;
  logic            PSEL;
  logic            PENABLE;
  logic [AD-1:0]   PADDR;
  logic            PWRITE;
  logic [DA-1:0]   PWDATA;
  logic            PREADY;
  logic            PSLVERR;
  logic [DA-1:0]   PRDATA;

  dpu_apb_arbiter #(
    .NUM_REQ      (N),
    .APB_WIDTH_AD (AD),
    .APB_WIDTH_DA (DA),
    .TIMEOUT      (16)
  ) dut (
    .PRESETn   (PRESETn),
    .PCLK      (PCLK),
    .REQ       (REQ),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .ACK       (ACK),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PRDATA    (PRDATA)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Slave model
  int   stall;
  bit   stuck;
  bit   slverr_en;
  int   wcnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wcnt <= 0;
    else if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else if (!PENABLE) wcnt <= 0;
  end

  assign PREADY  = !stuck && (wcnt >= stall);
  assign PSLVERR = slverr_en;

  always_comb begin
    PRDATA = 32'hBAD0_0000;
    if (PADDR == CSRA_VERSION) PRDATA = 32'h2021_0610;
    if (PADDR == CSRA_CONFIG)  PRDATA = 32'h0020_0020;
    if (PADDR == CSRA_STATUS)  PRDATA = 32'h0000_00A5;
  end

  // Scoreboard
  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_assert;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    REQ_WRITE[i]         = wr;
    REQ_ADDR[i*AD +: AD] = a;
    REQ_WDATA[i*DA +: DA] = d;
  endtask

  task automatic push(input int i, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] rd,
                      input logic e, input int c);
    exp_t x;
    x.idx = i; x.wr = wr; x.addr = a; x.wdata = d;
    x.rdata = rd; x.err = e; x.cyc = c;
    sb.push_back(x);
  endtask

  // Called at a negedge right after REQ is driven (cycle 0).
  task automatic run(input int max_cyc);
    int   cyc;
    bit   first;
    exp_t e;
    logic [N-1:0] oh;
    cyc   = 0;
    first = 1'b1;
    while (sb.size() > 0 && cyc < max_cyc) begin
      @(negedge PCLK);
      cyc++;
      if (first && cyc == 1) begin
        chk("psel_c1", 32'(PSEL), 32'd1);
        chk("pen_c1", 32'(PENABLE), 32'd0);
      end
      if (first && cyc == 2) chk("pen_c2", 32'(PENABLE), 32'd1);
      if (PSEL) begin
        chk("paddr", PADDR, sb[0].addr);
        chk("pwrite", 32'(PWRITE), 32'(sb[0].wr));
        chk("pwdata", PWDATA, sb[0].wdata);
      end
      if (ACK != '0) begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        chk("ack", 32'(ACK), 32'(oh));
        chk("rdata", RDATA, e.rdata);
        chk("err", 32'(ERR), 32'(e.err));
        chk("ack_cyc", 32'(cyc), 32'(e.cyc));
        first = 1'b0;
        if (sb.size() == 0) REQ = '0;
      end
    end
    chk("sb_left", 32'(sb.size()), 32'd0);
    sb.delete();
    REQ = '0;
    @(negedge PCLK);
    chk("ack_clr", 32'(ACK), 32'd0);
    chk("rdata_clr", RDATA, 32'd0);
    chk("err_clr", 32'(ERR), 32'd0);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    stall     = 0;
    stuck     = 1'b0;
    slverr_en = 1'b0;
    PRESETn   = 1'b0;
    REQ       = '0;
    REQ_WRITE = '0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;

    // Reset state
    repeat (2) @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_pen", 32'(PENABLE), 32'd0);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Single VERSION read by requester 0
    set_req(0, 1'b0, CSRA_VERSION, 32'h1111_0000);
    push(0, 1'b0, CSRA_VERSION, 32'h1111_0000, 32'h2021_0610, 1'b0, 3);
    REQ = 2'b01;
    run(20);

    // CONFIG read by requester 1
    set_req(1, 1'b0, CSRA_CONFIG, 32'h2222_0000);
    push(1, 1'b0, CSRA_CONFIG, 32'h2222_0000, 32'h0020_0020, 1'b0, 3);
    REQ = 2'b10;
    run(20);

    // Contention: alternating grants, ACKs 4 cycles apart
    set_req(0, 1'b0, CSRA_VERSION, 32'h0);
    set_req(1, 1'b0, CSRA_CONFIG, 32'h0);
    push(0, 1'b0, CSRA_VERSION, 32'h0, 32'h2021_0610, 1'b0, 3);
    push(1, 1'b0, CSRA_CONFIG, 32'h0, 32'h0020_0020, 1'b0, 7);
    push(0, 1'b0, CSRA_VERSION, 32'h0, 32'h2021_0610, 1'b0, 11);
    push(1, 1'b0, CSRA_CONFIG, 32'h0, 32'h0020_0020, 1'b0, 15);
    REQ = 2'b11;
    run(40);

    // Three wait states
    stall = 3;
    set_req(0, 1'b0, CSRA_STATUS, 32'h0);
    push(0, 1'b0, CSRA_STATUS, 32'h0, 32'h0000_00A5, 1'b0, 6);
    REQ = 2'b01;
    run(30);
    stall = 0;

    // Timeout abort
    stuck = 1'b1;
    set_req(1, 1'b0, CSRA_VERSION, 32'h0);
    push(1, 1'b0, CSRA_VERSION, 32'h0, 32'h0, 1'b1, 18);
    REQ = 2'b10;
    run(40);
    stuck = 1'b0;

    // Write with slave error
    slverr_en = 1'b1;
    set_req(0, 1'b1, CSRA_STATUS, 32'hDEAD_BEEF);
    push(0, 1'b1, CSRA_STATUS, 32'hDEAD_BEEF, 32'h0, 1'b1, 3);
    REQ = 2'b01;
    run(20);
    slverr_en = 1'b0;

    // Reset during ACCESS
    set_req(1, 1'b0, CSRA_CONFIG, 32'h0);
    REQ = 2'b10;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_pen", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(PSEL), 32'd0);
    chk("mid_rst_pen", 32'(PENABLE), 32'd0);
    chk("mid_rst_ack", 32'(ACK), 32'd0);
    REQ = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_hold_ack", 32'(ACK), 32'd0);
    PRESETn = 1'b1;
    set_req(0, 1'b0, CSRA_VERSION, 32'h0);
    set_req(1, 1'b0, CSRA_CONFIG, 32'h0);
    push(0, 1'b0, CSRA_VERSION, 32'h0, 32'h2021_0610, 1'b0, 3);
    REQ = 2'b11;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
